// File: rtl/vga_pkg.sv
// vga_pkg: shared definitions for the VGA palette path.
//   RGB_W        - pixel colour width, packed {R[23:16], G[15:8], B[7:0]}
//   clr_idx_t    - named indices of the sixteen standard text-mode colours
//   DEFAULT_PAL  - reset contents of palette entries 0..15
//   default_rgb  - reset value for any palette entry (0 above entry 15)
package vga_pkg;

  localparam int RGB_W        = 24;
  localparam int PAL_DEFAULTS = 16;

  typedef logic [RGB_W-1:0] rgb_t;

  typedef enum logic [3:0] {
    CLR_BLACK, CLR_BLUE, CLR_GREEN, CLR_CYAN,
    CLR_RED, CLR_MAGENTA, CLR_BROWN, CLR_LIGHT_GRAY,
    CLR_DARK_GRAY, CLR_BRIGHT_BLUE, CLR_BRIGHT_GREEN, CLR_BRIGHT_CYAN,
    CLR_BRIGHT_RED, CLR_BRIGHT_MAGENTA, CLR_YELLOW, CLR_WHITE
  } clr_idx_t;

  localparam rgb_t DEFAULT_PAL [PAL_DEFAULTS] = '{
    24'h000000, 24'h0000AA, 24'h00AA00, 24'h00AAAA,
    24'hAA0000, 24'hAA00AA, 24'hAA5500, 24'hAAAAAA,
    24'h555555, 24'h5555FF, 24'h55FF55, 24'h55FFFF,
    24'hFF5555, 24'hFF55FF, 24'hFFFF55, 24'hFFFFFF
  };

  function automatic rgb_t default_rgb(input int idx);
    if (idx >= 0 && idx < PAL_DEFAULTS) return DEFAULT_PAL[idx[3:0]];
    return '0;
  endfunction

endpackage

// File: rtl/vga_blink_timer.sv
// vga_blink_timer: frame-based blink phase generator.
//   clk          - pixel clock
//   rst          - asynchronous active-high reset
//   frame_start  - one-cycle pulse per frame
//   blink_phase  - toggles every BLINK_FRAMES frames; 1 = blinking fg shows bg
// Only instantiated when VGA_PALETTE_BLINK_EN is defined.
module vga_blink_timer #(
  parameter int BLINK_FRAMES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic frame_start,
  output logic blink_phase
);

  localparam int CNT_W = (BLINK_FRAMES > 2) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [CNT_W-1:0] LAST_FRAME = CNT_W'(BLINK_FRAMES - 1);

  logic [CNT_W-1:0] frame_cnt;
  logic             wrap;

  assign wrap = frame_start && (frame_cnt == LAST_FRAME);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (frame_start) begin
      frame_cnt <= wrap ? '0 : frame_cnt + 1'b1;
      if (wrap) blink_phase <= ~blink_phase;
    end
  end

endmodule

// File: rtl/vga_palette_lut.sv
// vga_palette_lut: two-stage programmable palette lookup.
//   clk, rst               - pixel clock, async active-high reset
//   pal_we/waddr/wdata     - palette entry write port
//   in_valid, in_de        - pixel qualifier and display enable
//   in_fb, in_fg, in_bg    - fg/bg select and colour indices
//   in_blink, frame_start  - blink attribute and frame pulse
//   out_valid, out_de      - inputs delayed by two clocks
//   out_rgb                - palette colour, 0 outside the active area
// Build option VGA_PALETTE_BLINK_EN: when defined, the blink timer is built
// and in_blink is honoured; otherwise blink is permanently off.
module vga_palette_lut
  import vga_pkg::*;
#(
  parameter int IDX_W        = 4,
  parameter int BLINK_FRAMES = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pal_we,
  input  logic [IDX_W-1:0] pal_waddr,
  input  logic [23:0]      pal_wdata,
  input  logic             in_valid,
  input  logic             in_de,
  input  logic             in_fb,
  input  logic [IDX_W-1:0] in_fg,
  input  logic [IDX_W-1:0] in_bg,
  input  logic             in_blink,
  input  logic             frame_start,
  output logic             out_valid,
  output logic             out_de,
  output logic [23:0]      out_rgb
);

  localparam int PAL_N = 1 << IDX_W;

  rgb_t             pal [PAL_N];
  rgb_t             rd_rgb;
  logic             blink_phase;
  logic             blank_fg;
  logic [IDX_W-1:0] idx1;
  logic             valid1;
  logic             de1;

`ifdef VGA_PALETTE_BLINK_EN
  vga_blink_timer #(
    .BLINK_FRAMES(BLINK_FRAMES)
  ) u_blink_timer (
    .clk        (clk),
    .rst        (rst),
    .frame_start(frame_start),
    .blink_phase(blink_phase)
  );
`else
  localparam int unused_blink_frames = BLINK_FRAMES;
  logic unused_frame_start;
  assign unused_frame_start = frame_start;
  assign blink_phase        = 1'b0;
`endif

  assign blank_fg = in_blink && blink_phase;

  // Stage 1: pick the colour index.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx1   <= '0;
      valid1 <= 1'b0;
      de1    <= 1'b0;
    end else begin
      idx1   <= (in_fb && !blank_fg) ? in_fg : in_bg;
      valid1 <= in_valid;
      de1    <= in_de;
    end
  end

  // Palette register file. Flops rather than RAM so reset restores defaults.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < PAL_N; i++) pal[i] <= default_rgb(i);
    end else begin
      for (int i = 0; i < PAL_N; i++) begin
        if (pal_we && (pal_waddr == IDX_W'(i))) pal[i] <= pal_wdata;
      end
    end
  end

  // Write-first: a write landing on the entry being read wins this cycle.
  assign rd_rgb = (pal_we && (pal_waddr == idx1)) ? pal_wdata : pal[idx1];

  // Stage 2: lookup and blanking.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_de    <= 1'b0;
      out_rgb   <= '0;
    end else begin
      out_valid <= valid1;
      out_de    <= de1;
      out_rgb   <= de1 ? rd_rgb : '0;
    end
  end

endmodule

// File: tb/tb_vga_palette_lut.sv
module tb_vga_palette_lut;

  localparam int IDX_W = 4;
  localparam int BF    = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic             pal_we;
  logic [IDX_W-1:0] pal_waddr;
  logic [23:0]      pal_wdata;
  logic             in_valid, in_de, in_fb, in_blink, frame_start;
  logic [IDX_W-1:0] in_fg, in_bg;
  logic             out_valid, out_de;
  logic [23:0]      out_rgb;

  vga_palette_lut #(.IDX_W(IDX_W), .BLINK_FRAMES(BF)) dut (
    .clk(clk), .rst(rst), .pal_we(pal_we), .pal_waddr(pal_waddr),
    .pal_wdata(pal_wdata), .in_valid(in_valid), .in_de(in_de),
    .in_fb(in_fb), .in_fg(in_fg), .in_bg(in_bg), .in_blink(in_blink),
    .frame_start(frame_start), .out_valid(out_valid), .out_de(out_de),
    .out_rgb(out_rgb)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;

  logic [23:0] spec_pal [16] = '{
    24'h000000, 24'h0000AA, 24'h00AA00, 24'h00AAAA,
    24'hAA0000, 24'hAA00AA, 24'hAA5500, 24'hAAAAAA,
    24'h555555, 24'h5555FF, 24'h55FF55, 24'h55FFFF,
    24'hFF5555, 24'hFF55FF, 24'hFFFF55, 24'hFFFFFF
  };

  // Reference model: palette contents, frames seen since reset, and the
  // pixels still travelling through the 2-clock delay.
  typedef struct {
    logic       valid;
    logic       de;
    logic [3:0] idx;
  } pix_t;

  logic [23:0] mpal [16];
  int          frames;
  pix_t        q[$];

  function automatic logic phase_now();
`ifdef VGA_PALETTE_BLINK_EN
    return ((frames / BF) % 2) == 1;
`else
    return 1'b0;
`endif
  endfunction

  task automatic model_reset();
    mpal   = spec_pal;
    frames = 0;
    q.delete();
  endtask

  task automatic idle_inputs();
    pal_we = 0; pal_waddr = '0; pal_wdata = '0;
    in_valid = 0; in_de = 0; in_fb = 0; in_fg = '0; in_bg = '0;
    in_blink = 0; frame_start = 0;
  endtask

  task automatic set_pixel(input logic v, input logic de, input logic fb,
                           input logic [3:0] fg, input logic [3:0] bg,
                           input logic blink);
    in_valid = v; in_de = de; in_fb = fb; in_fg = fg; in_bg = bg;
    in_blink = blink;
  endtask

  // Advance one clock with current inputs; returns what the outputs must
  // show afterwards.
  task automatic tick(output logic ev, output logic ed, output logic [23:0] er);
    pix_t p;
    pix_t o;
    p.valid = in_valid;
    p.de    = in_de;
    p.idx   = (in_fb && !(in_blink && phase_now())) ? in_fg : in_bg;
    q.push_back(p);
    if (pal_we) mpal[pal_waddr] = pal_wdata;
    if (frame_start) frames++;
    @(posedge clk);
    @(negedge clk);
    if (q.size() >= 2) begin
      o  = q.pop_front();
      ev = o.valid;
      ed = o.de;
      er = o.de ? mpal[o.idx] : 24'h0;
    end else begin
      ev = 0; ed = 0; er = 24'h0;
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1;
    frame_start = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({out_valid, out_de, out_rgb} !== 26'h0)
      $display("FAIL reset_outputs: got v=%b de=%b rgb=%h, expected 0/0/000000",
               out_valid, out_de, out_rgb);
    else passed++;
    rst = 0;
    frame_start = 0;
    model_reset();
  endtask

  task automatic test_defaults();
    logic ev, ed; logic [23:0] er;
    for (int k = 0; k < 3; k++) begin
      case (k)
        0: set_pixel(1, 1, 1, 4'd4, 4'd0, 0);
        1: set_pixel(1, 1, 0, 4'd0, 4'd15, 0);
        default: set_pixel(0, 0, 0, 4'd0, 4'd0, 0);
      endcase
      tick(ev, ed, er);
      checks++;
      if ({out_valid, out_de, out_rgb} !== {ev, ed, er})
        $display("FAIL defaults[%0d]: got v=%b de=%b rgb=%h, expected %b/%b/%h",
                 k, out_valid, out_de, out_rgb, ev, ed, er);
      else passed++;
      if (k == 1) begin
        checks++;
        if (out_rgb !== 24'hAA0000)
          $display("FAIL default_idx4: got %h, expected AA0000", out_rgb);
        else passed++;
      end
    end
  endtask

  task automatic test_blanking();
    logic ev, ed; logic [23:0] er;
    for (int k = 0; k < 3; k++) begin
      if (k < 2) set_pixel(1, 0, 1, 4'd15, 4'd9, 0);
      else set_pixel(0, 0, 0, 4'd0, 4'd0, 0);
      tick(ev, ed, er);
      checks++;
      if ({out_valid, out_de, out_rgb} !== {ev, ed, er})
        $display("FAIL blanking[%0d]: got v=%b de=%b rgb=%h, expected %b/%b/%h",
                 k, out_valid, out_de, out_rgb, ev, ed, er);
      else passed++;
    end
  endtask

  task automatic test_collision();
    logic ev, ed; logic [23:0] er;
    for (int k = 0; k < 4; k++) begin
      pal_we = 0;
      case (k)
        0: set_pixel(1, 1, 1, 4'd3, 4'd0, 0);
        1: begin
          set_pixel(1, 1, 0, 4'd0, 4'd3, 0);
          pal_we = 1; pal_waddr = 4'd3; pal_wdata = 24'h123456;
        end
        default: set_pixel(1, 1, 1, 4'd7, 4'd0, 0);
      endcase
      tick(ev, ed, er);
      checks++;
      if ({out_valid, out_de, out_rgb} !== {ev, ed, er})
        $display("FAIL collision[%0d]: got v=%b de=%b rgb=%h, expected %b/%b/%h",
                 k, out_valid, out_de, out_rgb, ev, ed, er);
      else passed++;
      if (k == 1 || k == 2) begin
        checks++;
        if (out_rgb !== 24'h123456)
          $display("FAIL collision_value[%0d]: got %h, expected 123456", k, out_rgb);
        else passed++;
      end
    end
    pal_we = 0;
  endtask

  task automatic test_blink();
    logic ev, ed; logic [23:0] er;
    for (int k = 0; k < 16; k++) begin
      set_pixel(1, 1, 1, 4'd14, 4'd1, 1);
      frame_start = (k % 3 == 0);
      tick(ev, ed, er);
      checks++;
      if ({out_valid, out_de, out_rgb} !== {ev, ed, er})
        $display("FAIL blink[%0d]: got v=%b de=%b rgb=%h, expected %b/%b/%h",
                 k, out_valid, out_de, out_rgb, ev, ed, er);
      else passed++;
    end
    frame_start = 0;
  endtask

  task automatic test_back_to_back();
    logic ev, ed; logic [23:0] er;
    for (int k = 0; k < 258; k++) begin
      if (k < 256) set_pixel(1, 1, k[4], k[3:0], k[3:0], 0);
      else set_pixel(0, 0, 0, 4'd0, 4'd0, 0);
      tick(ev, ed, er);
      checks++;
      if ({out_valid, out_de, out_rgb} !== {ev, ed, er})
        $display("FAIL stream[%0d]: got v=%b de=%b rgb=%h, expected %b/%b/%h",
                 k, out_valid, out_de, out_rgb, ev, ed, er);
      else passed++;
    end
  endtask

  task automatic test_random();
    logic ev, ed; logic [23:0] er;
    for (int k = 0; k < 300; k++) begin
      set_pixel(1'($urandom), 1'($urandom_range(0, 3) != 0), 1'($urandom),
                4'($urandom), 4'($urandom), 1'($urandom));
      pal_we      = ($urandom_range(0, 3) == 0);
      pal_waddr   = 4'($urandom);
      pal_wdata   = 24'($urandom);
      frame_start = ($urandom_range(0, 4) == 0);
      tick(ev, ed, er);
      checks++;
      if ({out_valid, out_de, out_rgb} !== {ev, ed, er})
        $display("FAIL random[%0d]: got v=%b de=%b rgb=%h, expected %b/%b/%h",
                 k, out_valid, out_de, out_rgb, ev, ed, er);
      else passed++;
    end
    idle_inputs();
  endtask

  task automatic test_reset_midstream();
    logic ev, ed; logic [23:0] er;
    for (int k = 0; k < 2; k++) begin
      set_pixel(1, 1, 1, 4'd15, 4'd0, 0);
      tick(ev, ed, er);
    end
    #2 rst = 1;
    frame_start = 1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_rgb !== 24'h0 || out_de !== 1'b0)
      $display("FAIL async_reset: got v=%b de=%b rgb=%h, expected 0/0/000000",
               out_valid, out_de, out_rgb);
    else passed++;
    @(posedge clk);
    @(negedge clk);
    rst = 0;
    frame_start = 0;
    model_reset();
    for (int k = 0; k < 3; k++) begin
      if (k == 0) set_pixel(1, 1, 1, 4'd3, 4'd0, 0);
      else set_pixel(0, 0, 0, 4'd0, 4'd0, 0);
      tick(ev, ed, er);
      checks++;
      if ({out_valid, out_de, out_rgb} !== {ev, ed, er})
        $display("FAIL post_reset[%0d]: got v=%b de=%b rgb=%h, expected %b/%b/%h",
                 k, out_valid, out_de, out_rgb, ev, ed, er);
      else passed++;
      if (k == 1) begin
        checks++;
        if (out_rgb !== 24'h00AAAA || out_valid !== 1'b1)
          $display("FAIL reset_restores_pal3: got v=%b rgb=%h, expected 1/00AAAA",
                   out_valid, out_rgb);
        else passed++;
      end
    end
  endtask

  initial begin
    idle_inputs();
    rst = 1;
    model_reset();
    @(negedge clk);
    test_reset();
    test_defaults();
    test_blanking();
    test_collision();
    test_blink();
    test_reset();
    test_back_to_back();
    test_random();
    test_reset_midstream();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
